// File: rtl/sqrt_csa_rsa.sv
// sqrt_csa_rsa: 9-bit unsigned adder with carry-in, built as a square-root
// carry-select adder whose blocks are ripple-carry chains of full adders.
// Block partition (LSB first): [1:0] plain ripple, [4:2] and [8:5] carry-select.
// The 10-bit sum (bit 9 is the carry-out) is registered once, giving one cycle
// of latency and one result per cycle.
//
// Interface: there is no valid/ready handshake. A, B and Cin are sampled on
// every rising clk edge and Out always shows the sum of the previous edge's
// inputs. Cin is a pure carry-in; subtraction is done by the caller (~B, Cin=1).

// ---------------------------------------------------------------------------
// 1-bit full adder: s = a^b^c, co = ab | c(a^b)
// ---------------------------------------------------------------------------
module sqrt_csa_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);
    logic w_p;

    // Propagate term, shared by the sum and the carry.
    assign w_p  = i_a ^ i_b;
    assign o_s  = w_p ^ i_c;
    assign o_co = (i_a & i_b) | (i_c & w_p);
endmodule

// ---------------------------------------------------------------------------
// W-bit ripple-carry adder made of chained full adders.
// ---------------------------------------------------------------------------
module sqrt_csa_rca #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_s,
    output logic         o_co
);
    logic [W:0] w_c;

    assign w_c[0] = i_ci;

    genvar g;
    generate
        for (g = 0; g < W; g++) begin : g_bit
            sqrt_csa_fa u_fa (
                .i_a  (i_a[g]),
                .i_b  (i_b[g]),
                .i_c  (w_c[g]),
                .o_s  (o_s[g]),
                .o_co (w_c[g+1])
            );
        end
    endgenerate

    assign o_co = w_c[W];
endmodule

// ---------------------------------------------------------------------------
// Carry-select block: two ripple adders precomputed with carry-in 0 and 1,
// the real incoming carry picks the sum bits and carry-out through 2:1 muxes.
// ---------------------------------------------------------------------------
module sqrt_csa_sel_blk #(
    parameter int W = 3
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sel,
    output logic [W-1:0] o_s,
    output logic         o_co
);
    logic [W-1:0] w_s0;
    logic [W-1:0] w_s1;
    logic         w_co0;
    logic         w_co1;

    sqrt_csa_rca #(.W(W)) u_rca_c0 (
        .i_a  (i_a),
        .i_b  (i_b),
        .i_ci (1'b0),
        .o_s  (w_s0),
        .o_co (w_co0)
    );

    sqrt_csa_rca #(.W(W)) u_rca_c1 (
        .i_a  (i_a),
        .i_b  (i_b),
        .i_ci (1'b1),
        .o_s  (w_s1),
        .o_co (w_co1)
    );

    // Late-arriving block carry only drives mux selects, never a ripple chain.
    assign o_s  = i_sel ? w_s1  : w_s0;
    assign o_co = i_sel ? w_co1 : w_co0;
endmodule

// ---------------------------------------------------------------------------
// Top: 2/3/4-bit block partition plus output register.
// ---------------------------------------------------------------------------
module sqrt_csa_rsa (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] A,
    input  logic [8:0] B,
    input  logic       Cin,
    output logic [9:0] Out
);
    logic [1:0] w_b0_sum;
    logic       w_b0_co;
    logic [2:0] w_b1_sum;
    logic       w_b1_co;
    logic [3:0] w_b2_sum;
    logic       w_b2_co;
    logic [9:0] w_sum;
    logic [9:0] r_out;

    // Block0: bits [1:0], plain ripple fed directly by Cin.
    sqrt_csa_rca #(.W(2)) u_blk0 (
        .i_a  (A[1:0]),
        .i_b  (B[1:0]),
        .i_ci (Cin),
        .o_s  (w_b0_sum),
        .o_co (w_b0_co)
    );

    // Block1: bits [4:2], selected by block0's carry-out.
    sqrt_csa_sel_blk #(.W(3)) u_blk1 (
        .i_a   (A[4:2]),
        .i_b   (B[4:2]),
        .i_sel (w_b0_co),
        .o_s   (w_b1_sum),
        .o_co  (w_b1_co)
    );

    // Block2: bits [8:5], selected by block1's carry-out; its carry is Out[9].
    sqrt_csa_sel_blk #(.W(4)) u_blk2 (
        .i_a   (A[8:5]),
        .i_b   (B[8:5]),
        .i_sel (w_b1_co),
        .o_s   (w_b2_sum),
        .o_co  (w_b2_co)
    );

    assign w_sum = {w_b2_co, w_b2_sum, w_b1_sum, w_b0_sum};

    // Register the sum every edge; reset clears it immediately and holds it at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= 10'd0;
        end else begin
            r_out <= w_sum;
        end
    end

    assign Out = r_out;
endmodule

// File: tb/tb_sqrt_csa_rsa.sv
// Self-checking bench for sqrt_csa_rsa: reset behaviour, directed sums with
// hand-computed results, block-boundary carries, then a back-to-back random run
// checked through an expected-value queue.
module tb_sqrt_csa_rsa;

  logic       clk;
  logic       rst;
  logic [8:0] a;
  logic [8:0] b;
  logic       cin;
  logic [9:0] out_w;

  int n_checks;
  int n_errors;

  logic [9:0] exp_q[$];

  sqrt_csa_rsa dut (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .Cin (cin),
    .Out (out_w)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [8:0] va, input logic [8:0] vb, input logic vc);
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vc;
  endtask

  // Apply one vector, then check it one edge later.
  task automatic apply_check(input string tag, input logic [8:0] va, input logic [8:0] vb,
                             input logic vc, input logic [9:0] exp);
    drive(va, vb, vc);
    @(posedge clk);
    #1;
    check_eq(tag, out_w, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    a   = 9'd7;
    b   = 9'd3;
    cin = 1'b0;

    // Reset held while clocking: output stays 0.
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("rst_hold", out_w, 10'd0);
    end

    // Release reset: next edge loads 7+3.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_release", out_w, 10'd10);

    // Reset asserted between edges clears the output immediately.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async", out_w, 10'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic sums.
    apply_check("sum_1_1",   9'd1,   9'd1,   1'b0, 10'd2);
    apply_check("sum_2_3",   9'd2,   9'd3,   1'b0, 10'd5);
    apply_check("sum_73_54", 9'd73,  9'd54,  1'b0, 10'd127);

    // Carry-in.
    apply_check("cin_4_3",   9'd4,   9'd3,   1'b1, 10'd8);
    apply_check("cin_16_8",  9'd16,  9'd8,   1'b1, 10'd25);
    apply_check("cin_0_1",   9'd0,   9'd1,   1'b1, 10'd2);
    apply_check("cin_56_25", 9'd56,  9'd25,  1'b1, 10'd82);

    // Overflow and full carry chain.
    apply_check("ovf_511_1",   9'd511, 9'd1,   1'b0, 10'd512);
    apply_check("chain_511_0", 9'd511, 9'd0,   1'b1, 10'd512);
    apply_check("max_sum",     9'd511, 9'd511, 1'b1, 10'd1023);
    apply_check("zero_sum",    9'd0,   9'd0,   1'b0, 10'd0);

    // Block-boundary carries.
    apply_check("blk0_co",   9'd3,   9'd1,   1'b0, 10'd4);
    apply_check("blk01_co",  9'd31,  9'd1,   1'b0, 10'd32);
    apply_check("blk_15_15", 9'd15,  9'd15,  1'b1, 10'd31);
    apply_check("blk1_sel",  9'd28,  9'd4,   1'b0, 10'd32);
    apply_check("blk2_only", 9'd480, 9'd32,  1'b0, 10'd512);

    // Back-to-back random traffic; each result is checked one edge after drive.
    for (int i = 0; i < 1000; i++) begin
      logic [8:0] ra;
      logic [8:0] rb;
      logic       rc;
      ra = 9'($urandom_range(0, 511));
      rb = 9'($urandom_range(0, 511));
      rc = 1'($urandom_range(0, 1));
      drive(ra, rb, rc);
      exp_q.push_back({1'b0, ra} + {1'b0, rb} + {9'd0, rc});
      @(posedge clk);
      #1;
      check_eq("random", out_w, exp_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
